// File: rtl/z16_pkg.sv
// Shared Z16 instruction-format definitions: opcodes, field positions,
// loader error codes and loader state encoding.
package z16_pkg;

  localparam logic [3:0] OP_LI = 4'hA;
  localparam logic [3:0] OP_ST = 4'hB;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 4;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 12;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_IMM  = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/z16_encoder.sv
// Combinational Z16 field packer, the mirror image of the decoder.
// Immediate opcodes carry a 4-bit signed immediate in place of one register field.
module z16_encoder
  import z16_pkg::*;
(
  input  logic [3:0]  i_opcode,
  input  logic [3:0]  i_rd,
  input  logic [3:0]  i_rs1,
  input  logic [3:0]  i_rs2,
  input  logic [15:0] i_imm,
  output logic [15:0] o_word,
  output logic        o_imm_ok
);

  // Fits in 4 signed bits when everything above bit 3 is a sign extension.
  function automatic logic imm_fits(input logic [15:0] imm);
    return (&imm[15:3]) | ~(|imm[15:3]);
  endfunction

  always_comb begin
    o_word                 = '0;
    o_imm_ok               = 1'b1;
    o_word[OPC_LSB +: 4]   = i_opcode;
    o_word[RD_LSB  +: 4]   = i_rd;
    o_word[RS1_LSB +: 4]   = i_rs1;
    o_word[RS2_LSB +: 4]   = i_rs2;
    if (i_opcode == OP_LI) begin
      o_word[RS2_LSB +: 4] = i_imm[3:0];
      o_imm_ok             = imm_fits(i_imm);
    end else if (i_opcode == OP_ST) begin
      o_word[RD_LSB +: 4]  = i_imm[3:0];
      o_imm_ok             = imm_fits(i_imm);
    end
  end

endmodule

// File: rtl/z16_instr_loader.sv
// Program loader: accepts field bundles, packs them into Z16 words and writes
// them to consecutive instruction-memory addresses, one bundle every two cycles.
module z16_instr_loader
  import z16_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_opcode,
  input  logic [3:0]        i_rd,
  input  logic [3:0]        i_rs1,
  input  logic [3:0]        i_rs2,
  input  logic [15:0]       i_imm,
  input  logic              i_last,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [ADDR_W:0]   o_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP  = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        err_q, err_d;
  logic              last_q, last_d;
  logic [15:0]       word_q, word_d;

  logic [15:0]       enc_word;
  logic              enc_ok;

  z16_encoder u_enc (
    .i_opcode (i_opcode),
    .i_rd     (i_rd),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_imm    (i_imm),
    .o_word   (enc_word),
    .o_imm_ok (enc_ok)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    last_d  = last_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) begin
          state_d = ST_LOAD;
          addr_d  = BASE;
          count_d = '0;
          err_d   = ERR_NONE;
        end
      end
      ST_LOAD: begin
        if (i_valid) begin
          if (enc_ok) begin
            word_d  = enc_word;
            last_d  = i_last;
            state_d = ST_WRITE;
          end else begin
            err_d   = ERR_IMM;
            state_d = ST_ERR;
          end
        end
      end
      ST_WRITE: begin
        count_d = count_q + 1'b1;
        // The top word is written but the address never wraps back to zero.
        if (addr_q != TOP) addr_d = addr_q + 1'b1;
        if (last_q) begin
          state_d = ST_DONE;
        end else if (addr_q == TOP) begin
          err_d   = ERR_OVF;
          state_d = ST_ERR;
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      count_q <= '0;
      err_q   <= ERR_NONE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  // Packed word is pure data; it is only visible while the strobe is high.
  always_ff @(posedge i_clk) begin
    word_q <= word_d;
  end

  assign o_ready     = (state_q == ST_LOAD);
  assign o_mem_wen   = (state_q == ST_WRITE);
  assign o_mem_addr  = o_mem_wen ? addr_q : '0;
  assign o_mem_wdata = o_mem_wen ? word_q : '0;
  assign o_busy      = (state_q == ST_LOAD) || (state_q == ST_WRITE);
  assign o_done      = (state_q == ST_DONE);
  assign o_err       = (state_q == ST_ERR);
  assign o_err_code  = err_q;
  assign o_count     = count_q;

endmodule

// File: tb/tb_z16_instr_loader.sv
// Bench for z16_instr_loader: a default-size instance and a 4-word instance
// (ADDR_W=2, BASE_ADDR=2) for the overflow corners.
module tb_z16_instr_loader;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
    logic        last;
  } bundle_t;

  typedef struct packed {
    bundle_t     b;
    logic [15:0] exp_word;
    logic        exp_ok;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [2];
  logic        valid [2];
  logic        last  [2];
  logic [3:0]  op    [2];
  logic [3:0]  rd    [2];
  logic [3:0]  rs1   [2];
  logic [3:0]  rs2   [2];
  logic [15:0] imm   [2];
  logic        ready [2];
  logic        wen   [2];
  logic [15:0] wdata [2];
  logic        busy  [2];
  logic        done  [2];
  logic        err   [2];
  logic [1:0]  ecode [2];
  logic [7:0]  addr0;
  logic [1:0]  addr1;
  logic [8:0]  count0;
  logic [2:0]  count1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  z16_instr_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .i_opcode(op[0]), .i_rd(rd[0]), .i_rs1(rs1[0]),
    .i_rs2(rs2[0]), .i_imm(imm[0]), .i_last(last[0]), .o_mem_wen(wen[0]),
    .o_mem_addr(addr0), .o_mem_wdata(wdata[0]), .o_busy(busy[0]),
    .o_done(done[0]), .o_err(err[0]), .o_err_code(ecode[0]), .o_count(count0)
  );

  z16_instr_loader #(.ADDR_W(2), .BASE_ADDR(2)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_valid(valid[1]),
    .o_ready(ready[1]), .i_opcode(op[1]), .i_rd(rd[1]), .i_rs1(rs1[1]),
    .i_rs2(rs2[1]), .i_imm(imm[1]), .i_last(last[1]), .o_mem_wen(wen[1]),
    .o_mem_addr(addr1), .o_mem_wdata(wdata[1]), .o_busy(busy[1]),
    .o_done(done[1]), .o_err(err[1]), .o_err_code(ecode[1]), .o_count(count1)
  );

  function automatic int unsigned get_addr(input int d);
    return (d == 0) ? int'(addr0) : int'(addr1);
  endfunction

  function automatic int unsigned get_count(input int d);
    return (d == 0) ? int'(count0) : int'(count1);
  endfunction

  // Reference packing: fields weighted by their nibble position.
  function automatic int unsigned model_word(input bundle_t b);
    int unsigned f_rd, f_rs2, lo4;
    lo4   = int'(b.imm) % 16;
    f_rd  = (b.op == 4'hB) ? lo4 : int'(b.rd);
    f_rs2 = (b.op == 4'hA) ? lo4 : int'(b.rs2);
    return int'(b.op) + 16 * f_rd + 256 * int'(b.rs1) + 4096 * f_rs2;
  endfunction

  function automatic bit model_legal(input bundle_t b);
    int v;
    v = int'($signed(b.imm));
    if (b.op != 4'hA && b.op != 4'hB) return 1'b1;
    return (v >= -8) && (v <= 7);
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input int d, input bundle_t b);
    op[d] = b.op; rd[d] = b.rd; rs1[d] = b.rs1; rs2[d] = b.rs2;
    imm[d] = b.imm; last[d] = b.last;
  endtask

  task automatic start_session(input int d);
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    chk("start_ready", ready[d], 1);
    chk("start_busy", busy[d], 1);
    chk("start_done", done[d], 0);
    chk("start_err", err[d], 0);
    chk("start_code", ecode[d], 0);
    chk("start_count", get_count(d), 0);
  endtask

  // Present one bundle, wait for acceptance, then check the write cycle.
  task automatic send(input int d, input bundle_t b, input bit exp_ok,
                      input int unsigned exp_word, input int unsigned exp_addr,
                      input int gap);
    int t;
    repeat (gap) step();
    set_bundle(d, b);
    valid[d] = 1'b1;
    t = 0;
    while (!ready[d] && t < 16) begin
      step();
      t++;
    end
    if (t == 16) begin
      chk("ready_timeout", 0, 1);
      valid[d] = 1'b0;
      return;
    end
    step();
    valid[d] = 1'b0;
    chk("wen", wen[d], exp_ok);
    if (exp_ok) begin
      chk("addr", get_addr(d), exp_addr);
      chk("wdata", wdata[d], exp_word);
      chk("ready_in_write", ready[d], 0);
      step();
    end
  endtask

  task automatic chk_all_zero(input int d);
    chk("rst_ready", ready[d], 0);
    chk("rst_wen", wen[d], 0);
    chk("rst_addr", get_addr(d), 0);
    chk("rst_wdata", wdata[d], 0);
    chk("rst_busy", busy[d], 0);
    chk("rst_done", done[d], 0);
    chk("rst_err", err[d], 0);
    chk("rst_code", ecode[d], 0);
    chk("rst_count", get_count(d), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t    tbl [9];
    bundle_t b, b2;
    bundle_t seq6 [4];
    bit      new_sess;
    int      n;

    tbl[0] = '{'{4'h1, 4'h2, 4'h3, 4'h4, 16'h0000, 1'b0}, 16'h4321, 1'b1};
    tbl[1] = '{'{4'hA, 4'h5, 4'h6, 4'hF, 16'hFFFD, 1'b0}, 16'hD65A, 1'b1};
    tbl[2] = '{'{4'hB, 4'h9, 4'h7, 4'h8, 16'h0005, 1'b1}, 16'h875B, 1'b1};
    tbl[3] = '{'{4'hA, 4'h1, 4'h2, 4'h3, 16'h0007, 1'b0}, 16'h721A, 1'b1};
    tbl[4] = '{'{4'hB, 4'h1, 4'h2, 4'h3, 16'hFFF8, 1'b0}, 16'h328B, 1'b1};
    tbl[5] = '{'{4'h3, 4'h1, 4'h2, 4'h3, 16'h0008, 1'b0}, 16'h3213, 1'b1};
    tbl[6] = '{'{4'hA, 4'h0, 4'h0, 4'h0, 16'h0008, 1'b0}, 16'h0000, 1'b0};
    tbl[7] = '{'{4'h5, 4'h4, 4'h5, 4'h6, 16'h1234, 1'b1}, 16'h6545, 1'b1};
    tbl[8] = '{'{4'hB, 4'h0, 4'h0, 4'h0, 16'hFFF7, 1'b0}, 16'h0000, 1'b0};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; valid[d] = 1'b0;
      set_bundle(d, '0);
    end
    step();
    step();
    chk_all_zero(0);
    chk_all_zero(1);
    rst_n = 1'b1;
    step();

    // Table sessions: a session ends on an illegal immediate or a last bundle.
    new_sess = 1'b1;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      if (new_sess) begin
        start_session(0);
        n = 0;
        new_sess = 1'b0;
      end
      send(0, tbl[i].b, tbl[i].exp_ok, tbl[i].exp_word, n, 0);
      if (!tbl[i].exp_ok) begin
        chk("tbl_err", err[0], 1);
        chk("tbl_code", ecode[0], 1);
        chk("tbl_busy", busy[0], 0);
        chk("tbl_count", get_count(0), n);
        step();
        chk("tbl_no_wen", wen[0], 0);
        new_sess = 1'b1;
      end else begin
        n++;
        if (tbl[i].b.last) begin
          chk("tbl_done", done[0], 1);
          chk("tbl_err_clr", err[0], 0);
          chk("tbl_count", get_count(0), n);
          new_sess = 1'b1;
        end else begin
          chk("tbl_load", ready[0], 1);
        end
      end
    end

    // Overflow on the 4-word instance: writes @2, @3, then error code 2.
    b  = '{4'h1, 4'h1, 4'h1, 4'h1, 16'h0, 1'b0};
    b2 = '{4'h2, 4'h2, 4'h2, 4'h2, 16'h0, 1'b0};
    start_session(1);
    send(1, b, 1'b1, 16'h1111, 2, 0);
    send(1, b2, 1'b1, 16'h2222, 3, 1);
    chk("ovf_err", err[1], 1);
    chk("ovf_code", ecode[1], 2);
    chk("ovf_count", get_count(1), 2);
    chk("ovf_done", done[1], 0);
    chk("ovf_no_wen", wen[1], 0);
    step();
    chk("ovf_no_wrap", wen[1], 0);
    chk("ovf_hold", ecode[1], 2);

    // Last bundle lands on the top address: done wins.
    start_session(1);
    send(1, b, 1'b1, 16'h1111, 2, 0);
    b2.last = 1'b1;
    send(1, b2, 1'b1, 16'h2222, 3, 0);
    chk("top_last_done", done[1], 1);
    chk("top_last_err", err[1], 0);
    chk("top_last_code", ecode[1], 0);
    chk("top_last_count", get_count(1), 2);

    // Reset held during the write cycle.
    start_session(0);
    set_bundle(0, '{4'h7, 4'h1, 4'h2, 4'h3, 16'h0, 1'b0});
    valid[0] = 1'b1;
    step();
    chk("pre_rst_wen", wen[0], 1);
    rst_n = 1'b0;
    step();
    chk_all_zero(0);
    step();
    chk("rst_hold_wen", wen[0], 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_ready", ready[0], 0);
      chk("idle_wen", wen[0], 0);
      chk("idle_busy", busy[0], 0);
    end
    valid[0] = 1'b0;

    // Back-to-back bundles with valid held high.
    for (int i = 0; i < 4; i++)
      seq6[i] = '{4'(i + 1), 4'(i), 4'(i + 2), 4'(i + 3), 16'h0, (i == 3)};
    start_session(0);
    set_bundle(0, seq6[0]);
    valid[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_ready", ready[0], (i % 2 == 0));
      chk("b2b_wen", wen[0], (i % 2 == 1));
      if (i % 2 == 1) begin
        chk("b2b_addr", get_addr(0), i / 2);
        chk("b2b_wdata", wdata[0], model_word(seq6[i / 2]));
        if (i / 2 + 1 < 4) set_bundle(0, seq6[i / 2 + 1]);
        else valid[0] = 1'b0;
      end
      step();
    end
    chk("b2b_done", done[0], 1);
    chk("b2b_count", get_count(0), 4);

    // Random sessions against the reference model.
    for (int s = 0; s < 8; s++) begin
      bit ended;
      bit ok;
      start_session(0);
      n = 0;
      ended = 1'b0;
      while (!ended) begin
        b.op  = 4'($urandom_range(0, 15));
        b.rd  = 4'($urandom);
        b.rs1 = 4'($urandom);
        b.rs2 = 4'($urandom);
        if ($urandom_range(0, 11) == 0) b.imm = 16'($urandom);
        else b.imm = 16'(int'($urandom_range(0, 15)) - 8);
        b.last = ($urandom_range(0, 7) == 0) || (n == 30);
        ok = model_legal(b);
        send(0, b, ok, model_word(b), n, $urandom_range(0, 2));
        if (!ok) begin
          chk("rnd_err", err[0], 1);
          chk("rnd_code", ecode[0], 1);
          chk("rnd_count", get_count(0), n);
          ended = 1'b1;
        end else begin
          n++;
          if (b.last) begin
            chk("rnd_done", done[0], 1);
            chk("rnd_count", get_count(0), n);
            ended = 1'b1;
          end
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/z16_instr_loader.md
Name: z16_instr_loader

Overview:
- Inverse of the Z16 instruction decoder: packs instruction fields (opcode, rd, rs1, rs2, imm) into 16-bit Z16 words.
- Writes the packed words sequentially into instruction memory.
- Sits between the host/boot interface and instruction memory; used to load programs before the core runs.
- Field packing matches the decoder's field layout exactly, so decode(encode(x)) round-trips.

Parameters:
ADDR_W, 8, instruction-memory address width; depth = 2^ADDR_W words
BASE_ADDR, 0, first write address after start (must be < 2^ADDR_W)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  synchronous active-low reset
i_start  in  1  begin load session (sampled only in IDLE, DONE, ERR)
i_valid  in  1  field bundle valid
o_ready  out  1  loader accepts bundle this cycle
i_opcode  in  4  opcode
i_rd  in  4  destination register
i_rs1  in  4  source register 1
i_rs2  in  4  source register 2
i_imm  in  16  signed immediate (opcodes 0xA, 0xB only)
i_last  in  1  marks final bundle of session
o_mem_wen  out  1  instruction-memory write strobe
o_mem_addr  out  ADDR_W  write address
o_mem_wdata  out  16  packed instruction
o_busy  out  1  state is LOAD or WRITE
o_done  out  1  session completed (level, held in DONE)
o_err  out  1  session aborted (level, held in ERR)
o_err_code  out  2  0 none, 1 imm out of range, 2 memory overflow
o_count  out  ADDR_W+1  words written in current session

Behaviour:
- Reset (i_rst_n=0 at edge): state IDLE; every output 0; internal address = BASE_ADDR. A reset during LOAD/WRITE aborts the session; no further write strobe occurs.
- Packing rules (combinational, registered on accept):
  - Base word: [3:0]=opcode, [7:4]=rd, [11:8]=rs1, [15:12]=rs2.
  - Opcode 0xA: [15:12]=imm[3:0]; i_rs2 ignored.
  - Opcode 0xB: [7:4]=imm[3:0]; i_rd ignored.
  - Other opcodes: i_imm ignored.
- Imm range check, opcodes 0xA/0xB only: legal iff imm[15:3] are all equal (range -8..7). Otherwise the bundle is a range error.
- State IDLE:
  - o_ready=0.
  - i_start=1 → LOAD; addr=BASE_ADDR; count=0; err_code=0.
- State LOAD:
  - o_ready=1.
  - On i_valid&o_ready with imm legal: latch packed word, addr, i_last → WRITE.
  - On i_valid&o_ready with imm illegal: no write; err_code=1 → ERR.
  - i_start is ignored.
- State WRITE (exactly one cycle):
  - o_ready=0; o_mem_wen=1; o_mem_addr = latched addr; o_mem_wdata = latched word.
  - Next cycle: count+1; addr+1.
  - latched last=1 → DONE.
  - Else if latched addr = 2^ADDR_W-1 → ERR with err_code=2. The top word is still written; addr does not wrap.
  - Otherwise → LOAD.
- Latency and throughput: accept-to-write strobe is 1 cycle; throughput is 1 bundle per 2 cycles.
- State DONE:
  - o_done=1; o_count holds.
  - i_start=1 → LOAD; new session starts with count cleared and o_done dropped.
- State ERR:
  - o_err=1; o_err_code holds.
  - i_start=1 → LOAD; err cleared.
- Simultaneous i_last with top address: DONE wins with err_code=0.
- i_valid while o_ready=0 has no effect. The bundle is not captured; the source must hold it.

Decomposition:
- Shared package z16_pkg:
  - Opcode constants OP_LI=4'hA, OP_ST=4'hB.
  - Field bit positions (OPC_LSB=0, RD_LSB=4, RS1_LSB=8, RS2_LSB=12).
  - Error code constants.
  - State enum.
- Sub-module z16_encoder: purely combinational packing plus imm range check, outputs word and imm_ok. It is the natural mirror of the decoder and is reused by testbenches.
- The FSM, address counter and handshake live in z16_instr_loader.

Test Plan:
1. Reset, start, 3 bundles (op 0x1 rd=2 rs1=3 rs2=4; op 0xA rd=5 rs1=6 imm=-3; op 0xB rs1=7 rs2=8 imm=5, last) → writes 0x4321@0, 0xD65A@1, 0x875B@2; o_done=1; o_count=3.
2. Op 0xA imm=8 (0x0008) → no o_mem_wen; o_err=1; o_err_code=1. Then i_start → LOAD; o_err=0; addr restarts at BASE_ADDR.
3. ADDR_W=2, BASE_ADDR=2, bundles without last → writes @2, @3, then ERR with code 2; no write @0.
4. Same setup as 3, but the 2nd bundle has i_last=1 → write @3; DONE; err_code=0.
5. i_rst_n=0 held during the WRITE cycle → no strobe after reset; all outputs 0; state IDLE. An i_valid before i_start is ignored.
6. i_valid held high continuously for 4 bundles → o_ready alternates 1/0; 4 writes, one every 2 cycles; each write strobe lands 1 cycle after its accept.
